// File: rtl/ifetch_pkg.sv
// ifetch_pkg: fetch FSM states, 8-bit ISA field encodings and the built-in default program.
package ifetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    typedef enum logic [1:0] {OP_ALU, OP_LDI, OP_BR, OP_JMP} op_t;
    localparam int FIELD_W = 2;
    localparam int OP_LSB = 6;
    localparam int RS_LSB = 4;
    localparam int RT_LSB = 2;
    localparam int IMM_LSB = 0;
    localparam int PROG_LEN = 4;
    localparam logic [7:0] DEFAULT_PROG [PROG_LEN] = '{8'h49, 8'hC1, 8'h18, 8'hA9};
endpackage

// File: rtl/ifetch_mem.sv
// ifetch_mem: instruction store with a registered read port and a single write port.
// IFETCH_LOAD_EN selects a writable RAM; otherwise a ROM of the package default program.
module ifetch_mem import ifetch_pkg::*; #(
    parameter int IW = 8,
    parameter int DEPTH = 32,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata
);
`ifdef IFETCH_LOAD_EN
    logic [IW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
`else
    logic [IW-1:0] mem [DEPTH];
    logic unused_w;
    assign unused_w = ^{we, waddr, wdata};
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        if (i < PROG_LEN) begin : g_prog
            assign mem[i] = IW'(DEFAULT_PROG[i]);
        end else begin : g_zero
            assign mem[i] = '0;
        end
    end
`endif
    // Only the read register is reset; stored words survive reset.
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IDLE/RUN/HALT fetch FSM with PC, one-bubble jump redirect and sticky fault.
// Define IFETCH_LOAD_EN to make the program memory loadable through the ld_* port.
module instr_fetch import ifetch_pkg::*; #(
    parameter int IW = 8,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk50,
    input  logic          reset,
    input  logic          run,
    input  logic          stall,
    input  logic          jump_valid,
    input  logic [AW:0]   jump_offset,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [IW-1:0] ld_data,
    output logic          ld_ready,
    output logic [IW-1:0] instr_out,
    output logic [AW-1:0] pc_out,
    output logic          instr_valid,
    output logic          halted,
    output logic          fault
);
    state_t state, state_n;
    logic [AW:0] pc, pc_n;
    logic [AW-1:0] pc_out_n;
    logic valid_n, fault_n, fetch, mem_we, target_bad;
    logic [AW+1:0] target;
    // pc is one bit wider than an address so that running off the end is representable.
    assign target = {2'b00, pc_out} + (AW+2)'(1) + {jump_offset[AW], jump_offset};
    assign target_bad = target[AW+1] || target[AW:0] >= (AW+1)'(DEPTH);
    assign halted = state == HALT;
`ifdef IFETCH_LOAD_EN
    assign ld_ready = state == IDLE;
`else
    assign ld_ready = 1'b0;
`endif
    assign mem_we = ld_valid && ld_ready && {1'b0, ld_addr} < (AW+1)'(DEPTH);
    always_comb begin
        state_n = state;
        pc_n = pc;
        pc_out_n = pc_out;
        valid_n = instr_valid;
        fault_n = fault;
        fetch = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_n = RUN;
                    pc_n = '0;
                end
            end
            RUN: begin
                if (!run) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end else if (!stall) begin
                    if (jump_valid && instr_valid) begin
                        valid_n = 1'b0;
                        if (target_bad) begin
                            state_n = HALT;
                            fault_n = 1'b1;
                        end else pc_n = target[AW:0];
                    end else if (pc == (AW+1)'(DEPTH)) begin
                        state_n = HALT;
                        valid_n = 1'b0;
                    end else begin
                        fetch = 1'b1;
                        pc_out_n = pc[AW-1:0];
                        valid_n = 1'b1;
                        pc_n = pc + 1'b1;
                    end
                end
            end
            HALT: state_n = run ? HALT : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk50) begin
        if (reset) begin
            state <= IDLE;
            pc <= '0;
            pc_out <= '0;
            instr_valid <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            pc_out <= pc_out_n;
            instr_valid <= valid_n;
            fault <= fault_n;
        end
    end
    ifetch_mem #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk(clk50),
        .rst(reset),
        .re(fetch),
        .raddr(pc[AW-1:0]),
        .rdata(instr_out),
        .we(mem_we),
        .waddr(ld_addr),
        .wdata(ld_data)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized control traffic against an integer model,
// and a DEPTH=5 instance for end-of-memory behaviour.
module tb_instr_fetch;
    localparam int D = 32;
    localparam int AW = 5;
    localparam int AW5 = 3;
`ifdef IFETCH_LOAD_EN
    localparam bit LOAD = 1'b1;
`else
    localparam bit LOAD = 1'b0;
`endif
    logic clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    logic reset = 1'b1, run = 1'b0, stall = 1'b0, jump_valid = 1'b0, ld_valid = 1'b0;
    logic [AW:0] jump_offset = '0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic ld_ready, instr_valid, halted, fault;
    logic [7:0] instr_out;
    logic [AW-1:0] pc_out;
    logic [16:0] obs;
    assign obs = {instr_out, pc_out, instr_valid, halted, fault, ld_ready};

    logic reset5 = 1'b1, run5 = 1'b0, zero5 = 1'b0, ld_valid5 = 1'b0;
    logic [AW5:0] off5 = '0;
    logic [AW5-1:0] ld_addr5 = '0;
    logic [7:0] ld_data5 = '0;
    logic ld_ready5, instr_valid5, halted5, fault5;
    logic [7:0] instr_out5;
    logic [AW5-1:0] pc_out5;

    instr_fetch #(.IW(8), .DEPTH(D)) dut (
        .clk50(clk50), .reset(reset), .run(run), .stall(stall), .jump_valid(jump_valid),
        .jump_offset(jump_offset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .halted(halted), .fault(fault)
    );
    instr_fetch #(.IW(8), .DEPTH(5)) dut5 (
        .clk50(clk50), .reset(reset5), .run(run5), .stall(zero5), .jump_valid(zero5),
        .jump_offset(off5), .ld_valid(ld_valid5), .ld_addr(ld_addr5), .ld_data(ld_data5),
        .ld_ready(ld_ready5), .instr_out(instr_out5), .pc_out(pc_out5), .instr_valid(instr_valid5),
        .halted(halted5), .fault(fault5)
    );

    int total = 0, bad = 0;
    int m_state, m_pc, m_pco, m_instr, m_v, m_f;
    int mmem [D];
    logic [7:0] prog [4] = '{8'h49, 8'hC1, 8'h18, 8'hA9};
    logic [7:0] p5 [5] = '{8'h49, 8'hC1, 8'h18, 8'hA9, 8'h00};

    // Model: 0 idle, 1 run, 2 halt; m_pc is the next address to fetch.
    task automatic model_step();
        int t;
        if (reset) begin
            m_state = 0; m_pc = 0; m_pco = 0; m_instr = 0; m_v = 0; m_f = 0;
        end else if (m_state == 0) begin
            if (LOAD && ld_valid && int'(ld_addr) < D) mmem[ld_addr] = int'(ld_data);
            if (run) begin m_state = 1; m_pc = 0; end
        end else if (!run) begin
            m_state = 0; m_v = 0;
        end else if (m_state == 1 && !stall) begin
            if (jump_valid && m_v == 1) begin
                t = m_pco + 1 + int'($signed(jump_offset));
                m_v = 0;
                if (t < 0 || t >= D) begin m_state = 2; m_f = 1; end
                else m_pc = t;
            end else if (m_pc == D) begin
                m_state = 2; m_v = 0;
            end else begin
                m_instr = mmem[m_pc]; m_pco = m_pc; m_v = 1; m_pc++;
            end
        end
    endtask

    function automatic logic [16:0] expv();
        return {8'(m_instr), 5'(m_pco), m_v[0], m_state == 2, m_f[0], LOAD && m_state == 0};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk50);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; stall = 1'b1; jump_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL reset_model cyc=%0d got=%h want=%h", c, obs, expv()); end
            total++;
            if ({instr_out, pc_out, instr_valid, halted, fault} !== 16'h0) begin
                bad++; $display("FAIL reset_zero got=%h want=0", {instr_out, pc_out, instr_valid, halted, fault});
            end
        end
        reset = 1'b0; run = 1'b0; stall = 1'b0; jump_valid = 1'b0;
    endtask

    task automatic test_load();
        for (int a = 0; a < D; a++) begin
            ld_valid = 1'b1; ld_addr = 5'(a); ld_data = 8'($urandom);
            tick();
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL load a=%0d got=%h want=%h", a, obs, expv()); end
        end
        ld_valid = 1'b0;
    endtask

    task automatic run_to(input int n);
        run = 1'b1;
        tick();
        for (int k = 0; k <= n; k++) tick();
    endtask

    task automatic test_seq();
        for (int a = 0; a < 4; a++) begin
            ld_valid = 1'b1; ld_addr = 5'(a); ld_data = prog[a];
            tick();
        end
        ld_valid = 1'b0; run = 1'b1;
        tick();
        total++;
        if (instr_valid !== 1'b0 || ld_ready !== 1'b0) begin
            bad++; $display("FAIL seq_first got v=%b rdy=%b want v=0 rdy=0", instr_valid, ld_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({instr_out, pc_out, instr_valid} !== {prog[k], 5'(k), 1'b1}) begin
                bad++; $display("FAIL seq k=%0d got %h@%0d v=%b want %h@%0d v=1", k, instr_out, pc_out, instr_valid, prog[k], k);
            end
        end
        run = 1'b0;
        tick();
        total++;
        if (obs !== expv() || instr_valid !== 1'b0) begin bad++; $display("FAIL seq_stop got=%h want=%h", obs, expv()); end
    endtask

    task automatic test_jump();
        run_to(1);
        jump_valid = 1'b1; jump_offset = 6'sd1;
        tick();
        jump_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL jump_bubble got v=%b want v=0", instr_valid); end
        tick();
        total++;
        if ({instr_out, pc_out, instr_valid} !== {8'hA9, 5'd3, 1'b1}) begin
            bad++; $display("FAIL jump_target got %h@%0d v=%b want a9@3 v=1", instr_out, pc_out, instr_valid);
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        run_to(2);
        stall = 1'b1; jump_valid = 1'b1; jump_offset = 6'sd2;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({instr_out, pc_out, instr_valid, halted} !== {8'h18, 5'd2, 1'b1, 1'b0}) begin
                bad++; $display("FAIL stall_hold cyc=%0d got %h@%0d v=%b want 18@2 v=1", c, instr_out, pc_out, instr_valid);
            end
        end
        stall = 1'b0;
        tick();
        jump_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL stall_bubble got v=%b want v=0", instr_valid); end
        tick();
        total++;
        if (obs !== expv() || pc_out !== 5'd5) begin bad++; $display("FAIL stall_target got=%h want=%h", obs, expv()); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_fault();
        run_to(2);
        jump_valid = 1'b1; jump_offset = -6'sd8;
        tick();
        jump_valid = 1'b0;
        total++;
        if ({halted, fault, instr_valid, pc_out} !== {3'b110, 5'd2}) begin
            bad++; $display("FAIL fault_halt got h=%b f=%b v=%b pc=%0d want h=1 f=1 v=0 pc=2", halted, fault, instr_valid, pc_out);
        end
        tick();
        run = 1'b0;
        tick();
        total++;
        if ({halted, fault, instr_valid, ld_ready} !== {3'b010, LOAD}) begin
            bad++; $display("FAIL fault_idle got h=%b f=%b v=%b rdy=%b want h=0 f=1 v=0", halted, fault, instr_valid, ld_ready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (fault !== 1'b0) begin bad++; $display("FAIL fault_clear got f=%b want f=0", fault); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(99) == 0);
            run = ($urandom_range(19) != 0);
            stall = ($urandom_range(3) == 0);
            jump_valid = ($urandom_range(6) == 0);
            jump_offset = 6'($urandom);
            ld_valid = 1'($urandom);
            ld_addr = 5'($urandom);
            ld_data = 8'($urandom);
            tick();
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", c, obs, expv()); end
        end
        reset = 1'b0; run = 1'b0; stall = 1'b0; jump_valid = 1'b0; ld_valid = 1'b0;
        tick();
    endtask

    task automatic test_depth5();
        reset5 = 1'b0;
        if (LOAD) begin
            for (int a = 0; a < 5; a++) begin
                ld_valid5 = 1'b1; ld_addr5 = 3'(a); ld_data5 = p5[a];
                tick();
            end
            ld_addr5 = 3'd6; ld_data5 = 8'hFF;
            tick();
            ld_valid5 = 1'b0;
        end
        run5 = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if ({instr_out5, pc_out5, instr_valid5, halted5} !== {p5[k], 3'(k), 1'b1, 1'b0}) begin
                bad++; $display("FAIL d5_seq k=%0d got %h@%0d v=%b h=%b want %h@%0d v=1", k, instr_out5, pc_out5, instr_valid5, halted5, p5[k], k);
            end
        end
        tick();
        total++;
        if ({halted5, fault5, instr_valid5, pc_out5} !== {3'b100, 3'd4}) begin
            bad++; $display("FAIL d5_end got h=%b f=%b v=%b pc=%0d want h=1 f=0 v=0 pc=4", halted5, fault5, instr_valid5, pc_out5);
        end
        run5 = 1'b0;
        tick();
        total++;
        if (halted5 !== 1'b0) begin bad++; $display("FAIL d5_idle got h=%b want h=0", halted5); end
        run5 = 1'b1;
        tick(); tick(); tick();
        total++;
        if ({pc_out5, instr_valid5} !== {3'd1, 1'b1}) begin
            bad++; $display("FAIL d5_rerun got pc=%0d v=%b want pc=1 v=1", pc_out5, instr_valid5);
        end
        reset5 = 1'b1;
        tick();
        total++;
        if ({instr_out5, pc_out5, instr_valid5, halted5, fault5} !== 14'h0) begin
            bad++; $display("FAIL d5_reset got=%h want=0", {instr_out5, pc_out5, instr_valid5, halted5, fault5});
        end
        reset5 = 1'b0; run5 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < D; i++) mmem[i] = (!LOAD && i < 4) ? int'(prog[i]) : 0;
        test_reset();
        test_load();
        test_seq();
        test_jump();
        test_stall();
        test_fault();
        test_random();
        test_depth5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter IW, default 8, instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, instruction memory words (2..256).
REQ-003 SHALL have localparam AW = clog2(DEPTH), the PC width.
REQ-004 SHALL have ports:
- clk50  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  level; 1 = fetch, 0 = return to IDLE.
- stall  in  1  core back-pressure; holds all fetch state.
- jump_valid  in  1  core redirect for the instruction currently on instr_out.
- jump_offset  in  AW+1  signed relative offset.
- ld_valid  in  1  program-load write strobe.
- ld_addr  in  AW  load word address.
- ld_data  in  IW  load word.
- ld_ready  out  1  load port accepting.
- instr_out  out  IW  fetched instruction.
- pc_out  out  AW  address of instr_out.
- instr_valid  out  1  instr_out is live.
- halted  out  1  in HALT state.
- fault  out  1  sticky illegal-target flag.

Function
REQ-005 SHALL implement states IDLE, RUN and HALT.
REQ-006 IDLE SHALL drive ld_ready=1; ld_valid&ld_ready with ld_addr<DEPTH SHALL write mem[ld_addr] at the edge; ld_addr>=DEPTH SHALL be dropped.
REQ-007 IDLE with run=1 SHALL enter RUN next cycle with pc=0.
REQ-008 RUN with stall=0 SHALL register instr_out<=mem[pc], pc_out<=pc, instr_valid<=1 and pc<=pc+1 each cycle (1-cycle read latency).
REQ-009 stall=1 SHALL hold pc, instr_out, pc_out and instr_valid unchanged.
REQ-010 jump_valid=1 with instr_valid=1 and stall=0 SHALL set pc<=pc_out+1+jump_offset, computed at AW+2 bits signed; the next cycle SHALL have instr_valid=0 (one squash bubble); the target word SHALL be valid the cycle after.
REQ-011 jump_valid SHALL be ignored when stall=1 or instr_valid=0; the core SHALL hold the request until accepted.
REQ-012 A jump target <0 or >=DEPTH SHALL enter HALT with fault=1.
REQ-013 A sequential increment reaching DEPTH SHALL enter HALT with fault=0, after the last word has been presented.
REQ-014 HALT SHALL drive halted=1 and instr_valid=0, and SHALL hold pc_out.
REQ-015 run=0 in RUN or HALT SHALL enter IDLE next cycle with instr_valid=0; fault SHALL stay set until reset.
REQ-016 ld_ready SHALL be 0 outside IDLE; ld_valid SHALL be ignored there.

Reset
REQ-017 reset SHALL force IDLE, pc=0, pc_out=0, instr_out=0, instr_valid=0, halted=0 and fault=0, and SHALL override run, stall and jump_valid in the same cycle.
REQ-018 reset SHALL NOT clear memory contents.

Configuration
REQ-019 With IFETCH_LOAD_EN defined, memory SHALL be RAM writable per REQ-006.
REQ-020 Without IFETCH_LOAD_EN, memory SHALL be a constant ROM from the package default program (unlisted words zero), ld_ready SHALL tie to 0 and the ld_* inputs SHALL be unused.

Structure
REQ-021 Package ifetch_pkg SHALL hold the state enum, the default-program constant array and the 2-bit field encodings (op, rs, rt, imm) of the 8-bit ISA.
REQ-022 The memory SHALL be sub-module ifetch_mem (synchronous read, single write port); the FSM and PC SHALL live in instr_fetch.

Verification
REQ-023 Load words 0x49,0xC1,0x18,0xA9 at 0..3, run=1 -> instr_out sequence 0x49,0xC1,0x18,0xA9 on pc_out 0..3 with no gaps, first valid two cycles after run.
REQ-024 jump_offset=+1 while instr_out=0xC1 (pc_out=1) -> one instr_valid=0 cycle, then pc_out=3.
REQ-025 stall high for 3 cycles mid-run with jump_valid also high -> outputs frozen, jump taken only on the first stall=0 cycle.
REQ-026 jump_offset=-8 at pc_out=2 -> HALT, halted=1, fault=1; run=0 -> IDLE with fault still 1; reset -> fault=0.
REQ-027 DEPTH=5 sequential run -> pc_out 0..4 presented, then halted=1, fault=0; reset asserted mid-RUN -> IDLE next cycle with all outputs zero.
